// File: rtl/game_pkg.sv
// Shared definitions for the snake game: direction codes, button indices and
// the direction-opposite helper used by the turn-acceptance logic.
package game_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_LEFT  = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_UP    = 2'd2;
    localparam dir_t DIR_DOWN  = 2'd3;

    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;
    localparam int BTN_S = 4;
    localparam int NUM_BTN = 5;

    // Codes are laid out so that opposite directions differ only in bit 0.
    function automatic dir_t opposite(input dir_t d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: two-flop synchroniser followed by a
// stable-count debouncer that toggles its level after DEBOUNCE_CYCLES agreement.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/snake_dir_input.sv
// Snake input stage: conditions the five buttons, keeps the committed direction
// with a one-deep turn queue released on each movement step, and pulses restart on S.
module snake_dir_input
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_s,
    input  logic       step,
    output logic [1:0] dir,
    output logic       pend_valid,
    output logic       restart,
    output logic [4:0] btn_db
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] db_level;
    logic [NUM_BTN-1:0] db_prev_q;
    logic [NUM_BTN-1:0] press_q, press_d;

    dir_t dir_q, dir_d;
    dir_t pend_q, pend_d;
    logic pend_valid_q, pend_valid_d;

    dir_t ref_dir;
    dir_t req_dir;
    logic req_valid;

    assign btn_raw = {btn_s, btn_u, btn_d, btn_l, btn_r};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_btn_debounce (
                .clk    (clk),
                .rst_n  (rst_n),
                .btn_raw(btn_raw[gi]),
                .btn_db (db_level[gi])
            );
        end
    endgenerate

    function automatic logic turn_ok(input dir_t req, input dir_t cur);
        return (req != cur) && (req != opposite(cur));
    endfunction

    assign press_d = db_level & ~db_prev_q;
    assign ref_dir = pend_valid_q ? pend_q : dir_q;

    // Only the highest-priority direction press is considered: U > L > D > R.
    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_RIGHT;
        if (press_q[BTN_U])      req_dir = DIR_UP;
        else if (press_q[BTN_L]) req_dir = DIR_LEFT;
        else if (press_q[BTN_D]) req_dir = DIR_DOWN;
        else if (press_q[BTN_R]) req_dir = DIR_RIGHT;
        else                     req_valid = 1'b0;
    end

    always_comb begin
        dir_d        = dir_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (press_q[BTN_S]) begin
            dir_d        = DIR_RIGHT;
            pend_d       = DIR_RIGHT;
            pend_valid_d = 1'b0;
        end else if (step) begin
            if (pend_valid_q) begin
                // The queued turn becomes the new heading; a same-cycle press
                // is judged against that heading and may re-fill the queue.
                dir_d        = pend_q;
                pend_valid_d = 1'b0;
                if (req_valid && turn_ok(req_dir, pend_q)) begin
                    pend_d       = req_dir;
                    pend_valid_d = 1'b1;
                end
            end else if (req_valid && turn_ok(req_dir, dir_q)) begin
                dir_d = req_dir;
            end
        end else if (req_valid && turn_ok(req_dir, ref_dir)) begin
            pend_d       = req_dir;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev_q    <= '0;
            press_q      <= '0;
            dir_q        <= DIR_RIGHT;
            pend_q       <= DIR_RIGHT;
            pend_valid_q <= 1'b0;
        end else begin
            db_prev_q    <= db_level;
            press_q      <= press_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign dir        = dir_q;
    assign pend_valid = pend_valid_q;
    assign restart    = press_q[BTN_S];
    assign btn_db     = db_level;

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed bench for snake_dir_input with a 4-cycle debounce: button timing,
// turn acceptance/queueing, same-cycle step handling, restart and async reset.
module tb_snake_dir_input;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_s = 1'b0;
    logic       step = 1'b0;
    logic [1:0] dir;
    logic       pend_valid;
    logic       restart;
    logic [4:0] btn_db;

    int total = 0;
    int bad   = 0;

    snake_dir_input #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_u     (btn_u),
        .btn_d     (btn_d),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .btn_s     (btn_s),
        .step      (step),
        .dir       (dir),
        .pend_valid(pend_valid),
        .restart   (restart),
        .btn_db    (btn_db)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mask bits {S,U,D,L,R}; held 8 cycles (press consumed) then released until db clears.
    task automatic press_btn(input logic [4:0] mask);
        {btn_s, btn_u, btn_d, btn_l, btn_r} = mask;
        tick(8);
        {btn_s, btn_u, btn_d, btn_l, btn_r} = 5'b0;
        tick(8);
    endtask

    task automatic do_step();
        step = 1'b1;
        tick(1);
        step = 1'b0;
    endtask

    initial begin
        // 1: reset and idle
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_dir", 8'(dir), 8'd1);
        chk("rst_pv", 8'(pend_valid), 8'd0);
        chk("rst_restart", 8'(restart), 8'd0);
        chk("rst_db", 8'(btn_db), 8'd0);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (dir !== 2'd1 || pend_valid !== 1'b0 || restart !== 1'b0 || btn_db !== 5'd0)
                chk("idle_state", {dir, pend_valid, restart, btn_db[3:0]}, 8'b0100_0000);
        end
        chk("idle_end", {1'b0, dir, pend_valid, restart, btn_db}, {1'b0, 2'd1, 1'b0, 1'b0, 5'd0});

        // 2: short glitch is filtered, long hold is accepted after 6 cycles
        btn_u = 1'b1;
        tick(3);
        btn_u = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (btn_db[3] !== 1'b0) chk("glitch_db", 8'(btn_db[3]), 8'd0);
        end
        chk("glitch_dir", 8'(dir), 8'd1);
        chk("glitch_pv", 8'(pend_valid), 8'd0);
        btn_u = 1'b1;
        tick(5);
        chk("hold_db_early", 8'(btn_db[3]), 8'd0);
        tick(1);
        chk("hold_db_rise", 8'(btn_db[3]), 8'd1);
        tick(1);
        chk("hold_pv_early", 8'(pend_valid), 8'd0);
        tick(1);
        chk("hold_pv", 8'(pend_valid), 8'd1);
        chk("hold_dir", 8'(dir), 8'd1);
        btn_u = 1'b0;
        tick(6);
        chk("release_db", 8'(btn_db[3]), 8'd0);
        tick(2);
        do_step();
        chk("step_dir_up", 8'(dir), 8'd2);
        chk("step_pv", 8'(pend_valid), 8'd0);

        // 3: reversal and same-direction rejection
        press_btn(5'b10000);
        chk("t3_restart_dir", 8'(dir), 8'd1);
        press_btn(5'b00010);
        chk("t3_L_rej_pv", 8'(pend_valid), 8'd0);
        press_btn(5'b00001);
        chk("t3_R_rej_pv", 8'(pend_valid), 8'd0);
        press_btn(5'b00100);
        chk("t3_D_pv", 8'(pend_valid), 8'd1);
        chk("t3_D_dir", 8'(dir), 8'd1);
        do_step();
        chk("t3_step_dir", 8'(dir), 8'd3);
        chk("t3_step_pv", 8'(pend_valid), 8'd0);

        // 4: queued U overwritten by L (checked against pending=2)
        press_btn(5'b10000);
        press_btn(5'b01000);
        chk("t4_U_pv", 8'(pend_valid), 8'd1);
        press_btn(5'b00010);
        chk("t4_L_pv", 8'(pend_valid), 8'd1);
        do_step();
        chk("t4_step_dir", 8'(dir), 8'd0);
        chk("t4_step_pv", 8'(pend_valid), 8'd0);

        // 5: simultaneous U+D, then press coincident with step
        press_btn(5'b10000);
        press_btn(5'b01100);
        chk("t5_UD_pv", 8'(pend_valid), 8'd1);
        do_step();
        chk("t5_UD_dir", 8'(dir), 8'd2);
        btn_l = 1'b1;
        tick(7);
        chk("t5_pre_dir", 8'(dir), 8'd2);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        chk("t5_same_dir", 8'(dir), 8'd0);
        chk("t5_same_pv", 8'(pend_valid), 8'd0);
        btn_l = 1'b0;
        tick(8);

        // 6: restart with a queued turn, then asynchronous reset mid-operation
        press_btn(5'b10000);
        press_btn(5'b01000);
        chk("t6_q_pv", 8'(pend_valid), 8'd1);
        btn_s = 1'b1;
        tick(6);
        chk("t6_rs_early", 8'(restart), 8'd0);
        tick(1);
        chk("t6_rs_pulse", 8'(restart), 8'd1);
        chk("t6_rs_pv_before", 8'(pend_valid), 8'd1);
        tick(1);
        chk("t6_rs_end", 8'(restart), 8'd0);
        chk("t6_rs_dir", 8'(dir), 8'd1);
        chk("t6_rs_pv", 8'(pend_valid), 8'd0);
        btn_s = 1'b0;
        tick(8);
        do_step();
        chk("t6_step_nop", 8'(dir), 8'd1);

        btn_u = 1'b1;
        tick(8);
        do_step();
        chk("t6_pre_dir", 8'(dir), 8'd2);
        chk("t6_pre_db", 8'(btn_db[3]), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dir", 8'(dir), 8'd1);
        chk("arst_pv", 8'(pend_valid), 8'd0);
        chk("arst_restart", 8'(restart), 8'd0);
        chk("arst_db", 8'(btn_db), 8'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("held_db_early", 8'(btn_db[3]), 8'd0);
        tick(1);
        chk("held_db_rise", 8'(btn_db[3]), 8'd1);
        tick(1);
        chk("held_pv_early", 8'(pend_valid), 8'd0);
        tick(1);
        chk("held_pv", 8'(pend_valid), 8'd1);
        btn_u = 1'b0;
        tick(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
